// File: rtl/lcd_sched_pkg.sv
// Shared definitions for the LCD write scheduler: FSM state encoding,
// default timing constants and the timer width.
package lcd_sched_pkg;

  // One state per phase of a 4-bit LCD byte write, in visiting order.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP_HI = 3'd1,
    ST_EN_HI    = 3'd2,
    ST_GAP_NIB  = 3'd3,
    ST_SETUP_LO = 3'd4,
    ST_EN_LO    = 3'd5,
    ST_GAP_BYTE = 3'd6
  } state_e;

  // Default phase lengths in clock cycles.
  localparam int unsigned T_SETUP_DEF = 2;
  localparam int unsigned T_EN_DEF    = 12;
  localparam int unsigned T_NIB_DEF   = 50;
  localparam int unsigned T_BYTE_DEF  = 2000;

  // Width of the shared phase timer; must hold the largest phase length.
  localparam int unsigned CNT_W = 16;

  // True while the high nibble is on the bus.
  function automatic logic is_hi_phase(state_e s);
    return (s == ST_SETUP_HI) || (s == ST_EN_HI) || (s == ST_GAP_NIB);
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Shared phase timer: loadable down-counter that flags the last cycle of a
// phase. A phase loaded with N lasts exactly N cycles.
//   clk, rst_n  : clock, async active-low reset (count cleared to 0)
//   load        : load load_val on this edge (takes priority)
//   load_val    : phase length in cycles
//   done_c      : combinational, high during the final cycle of the phase
module lcd_delay_counter
  import lcd_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count of 1 marks the last cycle; 0 (idle) never signals done.
  assign done_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/lcd_write_scheduler.sv
// Two-requester round-robin scheduler driving a 4-bit LCD write interface.
// Each granted byte is sent as high nibble then low nibble with setup,
// enable and gap phases timed by one shared down-counter.
//   Clock, Reset             : clock, async active-low reset
//   iReqN/iDataN/iRSN        : level request, byte and register select per requester
//   oAckN                    : one-cycle pulse after the capture edge
//   oBusy                    : high whenever a byte is in flight
//   oLCD_*                   : LCD strobe, RS, RW (tied 0), StrataFlash (tied 1), nibble bus
module lcd_write_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_EN    = T_EN_DEF,
  parameter int unsigned T_NIB   = T_NIB_DEF,
  parameter int unsigned T_BYTE  = T_BYTE_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iReq0,
  input  logic       iReq1,
  input  logic [7:0] iData0,
  input  logic [7:0] iData1,
  input  logic       iRS0,
  input  logic       iRS1,
  output logic       oAck0,
  output logic       oAck1,
  output logic       oBusy,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             rs_cap_q, rs_cap_d;
  logic             last_q, last_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic             en_q, en_d;
  logic             rs_q, rs_d;
  logic [3:0]       nib_q, nib_d;
  logic             grant1_c;
  logic             load_c;
  logic             done_c;
  logic [CNT_W-1:0] load_val_c;

  // Phase length for the state being entered; idle parks the timer at 0.
  function automatic logic [CNT_W-1:0] state_len(state_e s);
    case (s)
      ST_SETUP_HI, ST_SETUP_LO: return CNT_W'(T_SETUP);
      ST_EN_HI, ST_EN_LO:       return CNT_W'(T_EN);
      ST_GAP_NIB:               return CNT_W'(T_NIB);
      ST_GAP_BYTE:              return CNT_W'(T_BYTE);
      default:                  return '0;
    endcase
  endfunction

  lcd_delay_counter u_timer (
    .clk      (Clock),
    .rst_n    (Reset),
    .load     (load_c),
    .load_val (load_val_c),
    .done_c   (done_c)
  );

  // Arbitration, phase sequencing and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    rs_cap_d = rs_cap_q;
    last_d   = last_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    load_c   = 1'b0;
    grant1_c = 1'b0;

    if (state_q == ST_IDLE) begin
      if (iReq0 || iReq1) begin
        // Requester 1 wins alone, or on contention when 0 was served last.
        grant1_c = iReq1 && (!iReq0 || !last_q);
        byte_d   = grant1_c ? iData1 : iData0;
        rs_cap_d = grant1_c ? iRS1 : iRS0;
        last_d   = grant1_c;
        ack0_d   = !grant1_c;
        ack1_d   = grant1_c;
        state_d  = ST_SETUP_HI;
        load_c   = 1'b1;
      end
    end else if (done_c) begin
      load_c = 1'b1;
      case (state_q)
        ST_SETUP_HI: state_d = ST_EN_HI;
        ST_EN_HI:    state_d = ST_GAP_NIB;
        ST_GAP_NIB:  state_d = ST_SETUP_LO;
        ST_SETUP_LO: state_d = ST_EN_LO;
        ST_EN_LO:    state_d = ST_GAP_BYTE;
        default:     state_d = ST_IDLE;
      endcase
    end

    load_val_c = state_len(state_d);

    // Outputs follow the next state so they line up with it after the edge.
    busy_d = (state_d != ST_IDLE);
    en_d   = (state_d == ST_EN_HI) || (state_d == ST_EN_LO);
    rs_d   = busy_d ? rs_cap_d : 1'b0;
    if (!busy_d) begin
      nib_d = 4'h0;
    end else if (is_hi_phase(state_d)) begin
      nib_d = byte_d[7:4];
    end else begin
      nib_d = byte_d[3:0];
    end
  end

  // Pointer resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      byte_q   <= 8'h00;
      rs_cap_q <= 1'b0;
      last_q   <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
      en_q     <= 1'b0;
      rs_q     <= 1'b0;
      nib_q    <= 4'h0;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      rs_cap_q <= rs_cap_d;
      last_q   <= last_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
      en_q     <= en_d;
      rs_q     <= rs_d;
      nib_q    <= nib_d;
    end
  end

  assign oAck0                   = ack0_q;
  assign oAck1                   = ack1_q;
  assign oBusy                   = busy_q;
  assign oLCD_Enabled            = en_q;
  assign oLCD_RegisterSelect     = rs_q;
  assign oLCD_Data               = nib_q;
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Scoreboard bench for lcd_write_scheduler: a cycle-counting reference model
// predicts every grant (winner, byte, RS, capture cycle); a monitor rebuilds
// each LCD transfer from the pins and compares it with the prediction.
module tb_lcd_write_scheduler;

  localparam int unsigned TS = 2;
  localparam int unsigned TE = 4;
  localparam int unsigned TN = 3;
  localparam int unsigned TB = 10;
  localparam int unsigned PERIOD   = 2*TS + 2*TE + TN + TB + 1;
  localparam int unsigned BUSY_LEN = PERIOD - 1;
  localparam int unsigned HI_LEN   = TS + TE + TN;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       iReq0 = 1'b0;
  logic       iReq1 = 1'b0;
  logic [7:0] iData0 = 8'h00;
  logic [7:0] iData1 = 8'h00;
  logic       iRS0 = 1'b0;
  logic       iRS1 = 1'b0;
  logic       oAck0, oAck1, oBusy, oLCD_Enabled, oLCD_RegisterSelect;
  logic       oLCD_ReadWrite, oLCD_StrataFlashControl;
  logic [3:0] oLCD_Data;

  lcd_write_scheduler #(
    .T_SETUP (TS),
    .T_EN    (TE),
    .T_NIB   (TN),
    .T_BYTE  (TB)
  ) dut (
    .Clock                   (Clock),
    .Reset                   (Reset),
    .iReq0                   (iReq0),
    .iReq1                   (iReq1),
    .iData0                  (iData0),
    .iData1                  (iData1),
    .iRS0                    (iRS0),
    .iRS1                    (iRS1),
    .oAck0                   (oAck0),
    .oAck1                   (oAck1),
    .oBusy                   (oBusy),
    .oLCD_Enabled            (oLCD_Enabled),
    .oLCD_RegisterSelect     (oLCD_RegisterSelect),
    .oLCD_ReadWrite          (oLCD_ReadWrite),
    .oLCD_StrataFlashControl (oLCD_StrataFlashControl),
    .oLCD_Data               (oLCD_Data)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       rs;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   served_ids[$];
  int   served_cyc[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   cyc      = 0;
  int   ack0_cnt = 0;
  int   ack1_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference model: a byte may start once the previous one's period has
  // elapsed; on contention the requester not served last wins.
  int m_next_free = 0;
  int m_last      = 1;
  always @(posedge Clock) begin
    int w;
    cyc++;
    if (!Reset) begin
      exp_q.delete();
      m_next_free = 0;
      m_last      = 1;
    end else if (cyc >= m_next_free && (iReq0 || iReq1)) begin
      if (iReq0 && iReq1) w = (m_last == 1) ? 0 : 1;
      else                w = iReq0 ? 0 : 1;
      exp_q.push_back('{id: w, data: (w == 1) ? iData1 : iData0,
                        rs: (w == 1) ? iRS1 : iRS0, cyc: cyc});
      m_last      = w;
      m_next_free = cyc + int'(PERIOD);
    end
  end

  // Monitor: rebuild each transfer from the pins, one sample per cycle.
  exp_t       cur;
  logic       in_txn = 1'b0;
  logic       prev_e = 1'b0;
  logic [3:0] prev_data = 4'h0;
  int         off = 0;
  logic       e_ok, d_ok, rs_ok;
  always @(negedge Clock) begin
    int         aid;
    logic       exp_e;
    logic [3:0] exp_n;
    check("rw_const", 32'(oLCD_ReadWrite), 32'd0);
    check("sf_const", 32'(oLCD_StrataFlashControl), 32'd1);
    if (!Reset) begin
      in_txn = 1'b0;
      prev_e = 1'b0;
    end else begin
      if (oLCD_Enabled && prev_e) check("e_data_stable", 32'(oLCD_Data), 32'(prev_data));
      if (oAck0 && oAck1) begin
        check("dual_ack", 32'd1, 32'd0);
      end else if (oAck0 || oAck1) begin
        aid = oAck1 ? 1 : 0;
        if (aid == 0) ack0_cnt++;
        else          ack1_cnt++;
        served_ids.push_back(aid);
        served_cyc.push_back(cyc);
        if (in_txn) check("ack_while_busy", 32'd1, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("grant_id", 32'(aid), 32'(cur.id));
          check("grant_cycle", 32'(cyc), 32'(cur.cyc));
          in_txn = 1'b1;
          off    = 0;
          e_ok   = 1'b1;
          d_ok   = 1'b1;
          rs_ok  = 1'b1;
        end
      end
      if (in_txn) begin
        if (oBusy) begin
          exp_e = (off >= int'(TS) && off < int'(TS + TE)) ||
                  (off >= int'(HI_LEN + TS) && off < int'(HI_LEN + TS + TE));
          exp_n = (off < int'(HI_LEN)) ? cur.data[7:4] : cur.data[3:0];
          if (oLCD_Enabled !== exp_e) e_ok = 1'b0;
          if (oLCD_Data !== exp_n) d_ok = 1'b0;
          if (oLCD_RegisterSelect !== cur.rs) rs_ok = 1'b0;
          off++;
        end else begin
          check("busy_len", 32'(off), 32'(BUSY_LEN));
          check("e_pattern", 32'(e_ok), 32'd1);
          check("nibbles", 32'(d_ok), 32'd1);
          check("rs_hold", 32'(rs_ok), 32'd1);
          in_txn = 1'b0;
        end
      end else if (!(oAck0 || oAck1)) begin
        check("idle_outputs", 32'({oBusy, oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data}), 32'd0);
      end
      prev_e    = oLCD_Enabled;
      prev_data = oLCD_Data;
    end
  end

  function automatic logic ack_of(input int id);
    return (id == 1) ? oAck1 : oAck0;
  endfunction

  task automatic set_req(input int id, input logic v, input logic [7:0] d, input logic rs);
    if (id == 1) begin
      iReq1 = v; iData1 = d; iRS1 = rs;
    end else begin
      iReq0 = v; iData0 = d; iRS0 = rs;
    end
  endtask

  // Hold a request until it has been acked n times, then drop it.
  task automatic serve(input int id, input logic [7:0] d, input logic rs, input int n);
    int got = 0;
    int t   = 0;
    @(negedge Clock);
    set_req(id, 1'b1, d, rs);
    while (got < n && t < 200 * n) begin
      @(negedge Clock);
      t++;
      if (ack_of(id)) got++;
    end
    set_req(id, 1'b0, d, rs);
    if (got < n) check("serve_timeout", 32'(got), 32'(n));
  endtask

  // Raise a request for at most ncyc cycles; drop it early if acked.
  task automatic pulse(input int id, input logic [7:0] d, input logic rs, input int ncyc,
                       output logic acked);
    acked = 1'b0;
    @(negedge Clock);
    set_req(id, 1'b1, d, rs);
    for (int i = 0; i < ncyc && !acked; i++) begin
      @(negedge Clock);
      if (ack_of(id)) acked = 1'b1;
    end
    set_req(id, 1'b0, d, rs);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge Clock);
    while (oBusy && t < 400) begin
      @(negedge Clock);
      t++;
    end
    if (oBusy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic rand_driver(input int id);
    logic acked;
    for (int k = 0; k < 10; k++) begin
      repeat ($urandom_range(0, 30)) @(negedge Clock);
      if ($urandom_range(0, 3) == 0)
        pulse(id, 8'($urandom), 1'($urandom), int'($urandom_range(1, 4)), acked);
      else
        serve(id, 8'($urandom), 1'($urandom), int'($urandom_range(1, 2)));
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int   a0, a1;
    int   t;
    logic acked;
    int   order_ref[4];

    // Reset values.
    #1 Reset = 1'b0;
    #2;
    check("rst_ack0", 32'(oAck0), 32'd0);
    check("rst_ack1", 32'(oAck1), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_en", 32'(oLCD_Enabled), 32'd0);
    check("rst_rs", 32'(oLCD_RegisterSelect), 32'd0);
    check("rst_data", 32'(oLCD_Data), 32'd0);
    check("rst_rw", 32'(oLCD_ReadWrite), 32'd0);
    check("rst_sf", 32'(oLCD_StrataFlashControl), 32'd1);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);

    // Contention from reset: requester 0 first, then alternate, back to back.
    served_ids.delete();
    served_cyc.delete();
    fork
      serve(0, 8'h3C, 1'b0, 2);
      serve(1, 8'hC3, 1'b1, 2);
    join
    wait_idle();
    order_ref = '{0, 1, 0, 1};
    check("rr_count", 32'(served_ids.size()), 32'd4);
    if (served_ids.size() == 4) begin
      for (int i = 0; i < 4; i++) check("rr_order", 32'(served_ids[i]), 32'(order_ref[i]));
      for (int i = 1; i < 4; i++)
        check("rr_spacing", 32'(served_cyc[i] - served_cyc[i-1]), 32'(PERIOD));
    end

    // Single data byte from requester 0.
    served_ids.delete();
    serve(0, 8'h41, 1'b1, 1);
    wait_idle();
    check("req0_single_count", 32'(served_ids.size()), 32'd1);

    // Single command byte from requester 1; no ack on port 0.
    a0 = ack0_cnt;
    serve(1, 8'h28, 1'b0, 1);
    wait_idle();
    check("req1_no_ack0", 32'(ack0_cnt), 32'(a0));

    // Request 0 pulsed and dropped while requester 1 is busy.
    a0 = ack0_cnt;
    acked = 1'b0;
    fork
      serve(1, 8'h5A, 1'b1, 1);
      begin
        repeat (6) @(negedge Clock);
        pulse(0, 8'h99, 1'b0, 3, acked);
      end
    join
    wait_idle();
    repeat (30) @(negedge Clock);
    check("dropped_req_pulse_ack", 32'(acked), 32'd0);
    check("dropped_req_ack0", 32'(ack0_cnt), 32'(a0));

    // Reset during the first enable pulse aborts the byte.
    serve(0, 8'hA5, 1'b1, 1);
    t = 0;
    while (!oLCD_Enabled && t < 20) begin
      @(negedge Clock);
      t++;
    end
    check("reach_en_hi", 32'(oLCD_Enabled), 32'd1);
    #1 Reset = 1'b0;
    #1;
    check("abort_en", 32'(oLCD_Enabled), 32'd0);
    check("abort_outputs", 32'({oAck0, oAck1, oBusy, oLCD_RegisterSelect, oLCD_Data}), 32'd0);
    check("abort_rw", 32'(oLCD_ReadWrite), 32'd0);
    check("abort_sf", 32'(oLCD_StrataFlashControl), 32'd1);
    a0 = ack0_cnt;
    a1 = ack1_cnt;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    repeat (40) @(negedge Clock);
    check("post_reset_no_ack", 32'(ack0_cnt + ack1_cnt), 32'(a0 + a1));

    // Randomized traffic from both requesters.
    fork
      rand_driver(0);
      rand_driver(1);
    join
    wait_idle();
    repeat (PERIOD + 5) @(negedge Clock);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("no_open_txn", 32'(in_txn), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
